// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - A64 subset decode constants: opcode patterns, ctrl bit map, ALU op codes.
package decode_pkg;

  localparam int CTRL_W = 16;

  // Control bundle bit positions
  localparam int REG2LOC    = 0;
  localparam int UNCOND_BR  = 1;
  localparam int FLAG_BR    = 2;
  localparam int ZERO_BR    = 3;
  localparam int BR_INVERT  = 4;
  localparam int MEM_READ   = 5;
  localparam int MEM_TO_REG = 6;
  localparam int MEM_WRITE  = 7;
  localparam int FLAG_WRITE = 8;
  localparam int ALU_SRC    = 9;
  localparam int ALU_OP_LSB = 10;
  localparam int ALU_OP_MSB = 11;
  localparam int REG_WRITE  = 12;
  localparam int MOVK       = 13;
  localparam int IS32       = 14;
  localparam int ILLEGAL    = 15;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC   = 2'b10;

  // CBZ/CBNZ match instr[30:24]; B instr[31:26]; B.cond instr[31:24];
  // MOV*/ADD/SUB instr[30:23]; LDUR/STUR instr[31:21].
  localparam logic [6:0]  CBZ_OP   = 7'b0110100;
  localparam logic [6:0]  CBNZ_OP  = 7'b0110101;
  localparam logic [5:0]  B_OP     = 6'b000101;
  localparam logic [7:0]  BCOND_OP = 8'b01010100;
  localparam logic [7:0]  MOVZ_OP  = 8'b10100101;
  localparam logic [7:0]  MOVK_OP  = 8'b11100101;
  localparam logic [7:0]  ADDI_OP  = 8'b00100010;
  localparam logic [7:0]  SUBI_OP  = 8'b10100010;
  localparam logic [7:0]  SUBSI_OP = 8'b11100010;
  localparam logic [10:0] LDUR_OP  = 11'b11111000010;
  localparam logic [10:0] STUR_OP  = 11'b11111000000;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational A64 subset decoder: instruction word to ctrl, fields, immediate.
module decode_comb import decode_pkg::*; #(
  parameter int IMM_W     = 64,
  parameter bit SUPPORT_W = 1'b1
) (
  input  logic [31:0]       instr_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        rn_o,
  output logic [4:0]        rm_o,
  output logic [IMM_W-1:0]  imm_o,
  output logic [3:0]        cond_o
);

  logic has_sf;
  logic illegal;

  always_comb begin
    ctrl_o  = '0;
    imm_o   = '0;
    cond_o  = '0;
    has_sf  = 1'b0;
    illegal = 1'b0;
    if (instr_i[30:24] == CBZ_OP || instr_i[30:24] == CBNZ_OP) begin
      ctrl_o[REG2LOC]               = 1'b1;
      ctrl_o[ZERO_BR]               = 1'b1;
      ctrl_o[BR_INVERT]             = (instr_i[30:24] == CBNZ_OP);
      ctrl_o[ALU_OP_MSB:ALU_OP_LSB] = ALU_OP_PASS_B;
      imm_o  = {{(IMM_W-21){instr_i[23]}}, instr_i[23:5], 2'b00};
      has_sf = 1'b1;
    end else if (instr_i[31:26] == B_OP) begin
      ctrl_o[UNCOND_BR] = 1'b1;
      imm_o = {{(IMM_W-28){instr_i[25]}}, instr_i[25:0], 2'b00};
    end else if (instr_i[31:24] == BCOND_OP && !instr_i[4]) begin
      ctrl_o[FLAG_BR] = 1'b1;
      imm_o  = {{(IMM_W-21){instr_i[23]}}, instr_i[23:5], 2'b00};
      cond_o = instr_i[3:0];
    end else if (instr_i[30:23] == MOVZ_OP || instr_i[30:23] == MOVK_OP) begin
      ctrl_o[REG_WRITE] = 1'b1;
      ctrl_o[ALU_SRC]   = 1'b1;
      ctrl_o[MOVK]      = (instr_i[30:23] == MOVK_OP);
      imm_o   = IMM_W'(instr_i[20:5]) << {instr_i[22:21], 4'b0000};
      has_sf  = 1'b1;
      // W-form moves only have two 16-bit lanes
      illegal = !instr_i[31] && instr_i[22];
    end else if (instr_i[30:23] == ADDI_OP || instr_i[30:23] == SUBI_OP ||
                 instr_i[30:23] == SUBSI_OP) begin
      ctrl_o[ALU_SRC]               = 1'b1;
      ctrl_o[ALU_OP_MSB:ALU_OP_LSB] = ALU_OP_FUNC;
      ctrl_o[FLAG_WRITE]            = (instr_i[30:23] == SUBSI_OP);
      ctrl_o[REG_WRITE]             = !(instr_i[30:23] == SUBSI_OP && instr_i[4:0] == 5'd31);
      imm_o  = instr_i[22] ? (IMM_W'(instr_i[21:10]) << 12) : IMM_W'(instr_i[21:10]);
      has_sf = 1'b1;
    end else if (instr_i[31:21] == LDUR_OP) begin
      ctrl_o[ALU_SRC]    = 1'b1;
      ctrl_o[MEM_READ]   = 1'b1;
      ctrl_o[MEM_TO_REG] = 1'b1;
      ctrl_o[REG_WRITE]  = 1'b1;
      imm_o = {{(IMM_W-9){instr_i[20]}}, instr_i[20:12]};
    end else if (instr_i[31:21] == STUR_OP) begin
      ctrl_o[ALU_SRC]   = 1'b1;
      ctrl_o[MEM_WRITE] = 1'b1;
      ctrl_o[REG2LOC]   = 1'b1;
      imm_o = {{(IMM_W-9){instr_i[20]}}, instr_i[20:12]};
    end else begin
      illegal = 1'b1;
    end

    if (has_sf && !instr_i[31]) begin
      if (SUPPORT_W) ctrl_o[IS32] = 1'b1;
      else           illegal      = 1'b1;
    end

    if (illegal) begin
      ctrl_o          = '0;
      ctrl_o[ILLEGAL] = 1'b1;
      imm_o           = '0;
      cond_o          = '0;
    end
  end

  assign rd_o = instr_i[4:0];
  assign rn_o = instr_i[9:5];
  assign rm_o = ctrl_o[REG2LOC] ? instr_i[4:0] : instr_i[20:16];

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with 2-entry skid buffer, flush and load-use bubble.
module decode_stage import decode_pkg::*; #(
  parameter int PC_W           = 64,
  parameter int IMM_W          = 64,
  parameter bit SUPPORT_W      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rn,
  output logic [4:0]        out_rm,
  output logic [IMM_W-1:0]  out_imm,
  output logic [3:0]        out_cond
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [IMM_W-1:0]  imm;
    logic [3:0]        cond;
  } entry_t;

  entry_t in_entry, next_entry;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   stall_q, stall_d;
  logic   in_fire, out_fire, next_valid;

  decode_comb #(.IMM_W(IMM_W), .SUPPORT_W(SUPPORT_W)) u_decode (
    .instr_i (in_instr),
    .ctrl_o  (in_entry.ctrl),
    .rd_o    (in_entry.rd),
    .rn_o    (in_entry.rn),
    .rm_o    (in_entry.rm),
    .imm_o   (in_entry.imm),
    .cond_o  (in_entry.cond)
  );
  assign in_entry.pc = in_pc;

  function automatic logic reads_reg(input entry_t e, input logic [4:0] r);
    return (e.rn == r) || (e.ctrl[REG2LOC] && e.rm == r);
  endfunction

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q && !stall_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // The skid entry is always older than anything arriving this cycle
  assign next_entry = skid_valid_q ? skid_q : in_entry;
  assign next_valid = skid_valid_q || in_fire;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || out_fire) begin
      main_valid_d = next_valid;
      if (next_valid) main_d = next_entry;
      skid_valid_d = 1'b0;
    end else if (in_fire) begin
      skid_valid_d = 1'b1;
      skid_d       = in_entry;
    end
    stall_d = LOAD_USE_STALL && out_fire && main_q.ctrl[MEM_READ] &&
              (main_q.rd != 5'd31) && next_valid && reads_reg(next_entry, main_q.rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= 1'b0;
    end else if (flush) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      stall_q      <= stall_d;
    end
  end

  assign out_pc   = main_q.pc;
  assign out_ctrl = main_q.ctrl;
  assign out_rd   = main_q.rd;
  assign out_rn   = main_q.rn;
  assign out_rm   = main_q.rm;
  assign out_imm  = main_q.imm;
  assign out_cond = main_q.cond;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - bench for decode_stage: decode vectors, handshake corners, random queue model.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  // index 0: default, 1: LOAD_USE_STALL=0, 2: SUPPORT_W=0
  logic        o_ir [3];
  logic        o_ov [3];
  logic [63:0] o_pc [3];
  logic [15:0] o_ctrl [3];
  logic [4:0]  o_rd [3];
  logic [4:0]  o_rn [3];
  logic [4:0]  o_rm [3];
  logic [63:0] o_imm [3];
  logic [3:0]  o_cond [3];

  always #5 clk = ~clk;

  decode_stage #(.PC_W(64), .IMM_W(64), .SUPPORT_W(1'b1), .LOAD_USE_STALL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[0]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(o_ov[0]), .out_ready(out_ready),
    .out_pc(o_pc[0]), .out_ctrl(o_ctrl[0]), .out_rd(o_rd[0]), .out_rn(o_rn[0]),
    .out_rm(o_rm[0]), .out_imm(o_imm[0]), .out_cond(o_cond[0]));

  decode_stage #(.PC_W(64), .IMM_W(64), .SUPPORT_W(1'b1), .LOAD_USE_STALL(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[1]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(o_ov[1]), .out_ready(out_ready),
    .out_pc(o_pc[1]), .out_ctrl(o_ctrl[1]), .out_rd(o_rd[1]), .out_rn(o_rn[1]),
    .out_rm(o_rm[1]), .out_imm(o_imm[1]), .out_cond(o_cond[1]));

  decode_stage #(.PC_W(64), .IMM_W(64), .SUPPORT_W(1'b0), .LOAD_USE_STALL(1'b1)) dut_nw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_ir[2]), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(o_ov[2]), .out_ready(out_ready),
    .out_pc(o_pc[2]), .out_ctrl(o_ctrl[2]), .out_rd(o_rd[2]), .out_rn(o_rn[2]),
    .out_rm(o_rm[2]), .out_imm(o_imm[2]), .out_cond(o_cond[2]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] C_R2L  = 16'(1 << REG2LOC);
  localparam logic [15:0] C_UB   = 16'(1 << UNCOND_BR);
  localparam logic [15:0] C_FB   = 16'(1 << FLAG_BR);
  localparam logic [15:0] C_ZB   = 16'(1 << ZERO_BR);
  localparam logic [15:0] C_BI   = 16'(1 << BR_INVERT);
  localparam logic [15:0] C_MR   = 16'(1 << MEM_READ);
  localparam logic [15:0] C_M2R  = 16'(1 << MEM_TO_REG);
  localparam logic [15:0] C_MW   = 16'(1 << MEM_WRITE);
  localparam logic [15:0] C_FW   = 16'(1 << FLAG_WRITE);
  localparam logic [15:0] C_AS   = 16'(1 << ALU_SRC);
  localparam logic [15:0] C_PASS = 16'(1 << ALU_OP_LSB);
  localparam logic [15:0] C_FUNC = 16'(2 << ALU_OP_LSB);
  localparam logic [15:0] C_RW   = 16'(1 << REG_WRITE);
  localparam logic [15:0] C_MK   = 16'(1 << MOVK);
  localparam logic [15:0] C_W    = 16'(1 << IS32);
  localparam logic [15:0] C_ILL  = 16'(1 << ILLEGAL);

  typedef struct {
    logic [31:0] instr;
    logic [15:0] ctrl;
    logic [15:0] nw_ctrl;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm;
    logic [3:0]  cond;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [15:0] ctrl;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm;
    logic [3:0]  cond;
  } dec_t;

  // Reference decode from the instruction-set rules, using integer arithmetic for immediates
  function automatic dec_t ref_decode(input logic [31:0] w, input bit supw);
    dec_t   d;
    longint v;
    bit     sfc, bad;
    int     hw;
    d = '{default: '0};
    sfc = 0;
    bad = 0;
    d.rd = w[4:0];
    d.rn = w[9:5];
    if (w[30:25] == 6'b011010) begin
      d.ctrl = C_R2L | C_ZB | C_PASS | (w[24] ? C_BI : 16'h0);
      v = longint'(w[23:5]);
      if (v >= (64'sd1 << 18)) v -= (64'sd1 << 19);
      d.imm = 64'(v * 4);
      sfc = 1;
    end else if (w[31:26] == 6'b000101) begin
      d.ctrl = C_UB;
      v = longint'(w[25:0]);
      if (v >= (64'sd1 << 25)) v -= (64'sd1 << 26);
      d.imm = 64'(v * 4);
    end else if (w[31:24] == 8'h54 && !w[4]) begin
      d.ctrl = C_FB;
      v = longint'(w[23:5]);
      if (v >= (64'sd1 << 18)) v -= (64'sd1 << 19);
      d.imm = 64'(v * 4);
      d.cond = w[3:0];
    end else if (w[30:23] == 8'hA5 || w[30:23] == 8'hE5) begin
      hw = int'(w[22:21]);
      d.ctrl = C_RW | C_AS | (w[29] ? C_MK : 16'h0);
      d.imm = 64'(longint'(w[20:5])) * (64'd1 << (16 * hw));
      if (!w[31] && hw >= 2) bad = 1;
      sfc = 1;
    end else if (w[30:23] == 8'h22 || w[30:23] == 8'hA2 || w[30:23] == 8'hE2) begin
      d.ctrl = C_AS | C_FUNC;
      if (w[30:23] == 8'hE2) d.ctrl |= C_FW;
      if (!(w[30:23] == 8'hE2 && w[4:0] == 5'd31)) d.ctrl |= C_RW;
      d.imm = 64'(longint'(w[21:10]) * (w[22] ? 4096 : 1));
      sfc = 1;
    end else if (w[31:21] == 11'h7C2 || w[31:21] == 11'h7C0) begin
      d.ctrl = (w[31:21] == 11'h7C2) ? (C_AS | C_MR | C_M2R | C_RW) : (C_AS | C_MW | C_R2L);
      v = longint'(w[20:12]);
      if (v >= 256) v -= 512;
      d.imm = 64'(v);
    end else begin
      bad = 1;
    end
    if (sfc && !w[31]) begin
      if (supw) d.ctrl |= C_W;
      else      bad = 1;
    end
    if (bad) begin
      d.ctrl = C_ILL;
      d.imm  = '0;
      d.cond = '0;
    end
    d.rm = d.ctrl[REG2LOC] ? w[4:0] : w[20:16];
    return d;
  endfunction

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: w[30:25] = 6'b011010;
      1: w[31:26] = 6'b000101;
      2: w[31:24] = 8'h54;
      3: w[30:23] = w[0] ? 8'hE5 : 8'hA5;
      4, 5: begin
        case ($urandom_range(0, 2))
          0:       w[30:23] = 8'h22;
          1:       w[30:23] = 8'hA2;
          default: w[30:23] = 8'hE2;
        endcase
      end
      6, 7: w[31:21] = 11'h7C2;
      8:    w[31:21] = 11'h7C0;
      default: ;
    endcase
    if (k != 9) begin
      w[4:0]   = pick_reg();
      w[9:5]   = pick_reg();
      w[20:16] = pick_reg();
    end
    return w;
  endfunction

  vec_t   vecs[15];
  dec_t   mq[$];
  dec_t   popped, nd;
  logic [63:0] got_pc[$];
  bit     m_stall, exp_ir, exp_ov, fire, accept;
  int     cnt;

  initial begin
    vecs[0]  = '{32'h91001441, C_RW|C_AS|C_FUNC,      C_RW|C_AS|C_FUNC,      5'd1,  5'd2,  5'd0,  64'd5,          4'd0};
    vecs[1]  = '{32'hB4000043, C_R2L|C_ZB|C_PASS,     C_R2L|C_ZB|C_PASS,     5'd3,  5'd2,  5'd3,  64'd8,          4'd0};
    vecs[2]  = '{32'hB5000043, C_R2L|C_ZB|C_PASS|C_BI, C_R2L|C_ZB|C_PASS|C_BI, 5'd3, 5'd2,  5'd3,  64'd8,          4'd0};
    vecs[3]  = '{32'hF84000A4, C_AS|C_MR|C_M2R|C_RW,  C_AS|C_MR|C_M2R|C_RW,  5'd4,  5'd5,  5'd0,  64'd0,          4'd0};
    vecs[4]  = '{32'h00000000, C_ILL,                 C_ILL,                 5'd0,  5'd0,  5'd0,  64'd0,          4'd0};
    vecs[5]  = '{32'h11001441, C_RW|C_AS|C_FUNC|C_W,  C_ILL,                 5'd1,  5'd2,  5'd0,  64'd5,          4'd0};
    vecs[6]  = '{32'h14000003, C_UB,                  C_UB,                  5'd3,  5'd0,  5'd0,  64'd12,         4'd0};
    vecs[7]  = '{32'h17FFFFFF, C_UB,                  C_UB,                  5'd31, 5'd31, 5'd31, 64'hFFFFFFFFFFFFFFFC, 4'd0};
    vecs[8]  = '{32'h54000081, C_FB,                  C_FB,                  5'd1,  5'd4,  5'd0,  64'd16,         4'd1};
    vecs[9]  = '{32'hF2A24680, C_RW|C_AS|C_MK,        C_RW|C_AS|C_MK,        5'd0,  5'd20, 5'd2,  64'h12340000,   4'd0};
    vecs[10] = '{32'h52C00000, C_ILL,                 C_ILL,                 5'd0,  5'd0,  5'd0,  64'd0,          4'd0};
    vecs[11] = '{32'hF1001C5F, C_AS|C_FUNC|C_FW,      C_AS|C_FUNC|C_FW,      5'd31, 5'd2,  5'd0,  64'd7,          4'd0};
    vecs[12] = '{32'hD1400441, C_RW|C_AS|C_FUNC,      C_RW|C_AS|C_FUNC,      5'd1,  5'd2,  5'd0,  64'd4096,       4'd0};
    vecs[13] = '{32'hF81F8041, C_MW|C_R2L|C_AS,       C_MW|C_R2L|C_AS,       5'd1,  5'd2,  5'd1,  64'hFFFFFFFFFFFFFFF8, 4'd0};
    vecs[14] = '{32'h54000090, C_ILL,                 C_ILL,                 5'd16, 5'd4,  5'd0,  64'd0,          4'd0};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step();
    step();
    chk("reset out_valid", 64'(o_ov[0]), 64'd0);
    chk("reset in_ready", 64'(o_ir[0]), 64'd1);
    chk("reset out_pc", o_pc[0], 64'd0);
    chk("reset out_ctrl", 64'(o_ctrl[0]), 64'd0);
    chk("reset out_imm", o_imm[0], 64'd0);
    rst = 1'b0;

    // Decode table, one instruction at a time with a free consumer
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 64'h1000 + 64'(i * 4);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 64'(o_ov[0]), 64'd1);
      chk($sformatf("vec%0d pc", i), o_pc[0], 64'h1000 + 64'(i * 4));
      chk($sformatf("vec%0d ctrl", i), 64'(o_ctrl[0]), 64'(vecs[i].ctrl));
      chk($sformatf("vec%0d rd/rn/rm", i), 64'({o_rd[0], o_rn[0], o_rm[0]}),
          64'({vecs[i].rd, vecs[i].rn, vecs[i].rm}));
      chk($sformatf("vec%0d imm", i), o_imm[0], vecs[i].imm);
      chk($sformatf("vec%0d cond", i), 64'(o_cond[0]), 64'(vecs[i].cond));
      chk($sformatf("vec%0d ctrl no-W", i), 64'(o_ctrl[2]), 64'(vecs[i].nw_ctrl));
      step();
    end

    // Load-use: LDUR X4 then ADD X6,X4,#1 back to back
    in_valid = 1'b1; in_instr = 32'hF84000A4; in_pc = 64'h100;
    step();
    in_instr = 32'h91000486; in_pc = 64'h104;
    chk("lu ldur valid", 64'(o_ov[0]), 64'd1);
    chk("lu ldur pc", o_pc[0], 64'h100);
    chk("lu ns ldur pc", o_pc[1], 64'h100);
    step();
    in_valid = 1'b0;
    chk("lu bubble", 64'(o_ov[0]), 64'd0);
    chk("lu ns no bubble valid", 64'(o_ov[1]), 64'd1);
    chk("lu ns no bubble pc", o_pc[1], 64'h104);
    step();
    chk("lu add valid", 64'(o_ov[0]), 64'd1);
    chk("lu add pc", o_pc[0], 64'h104);
    chk("lu add rn", 64'(o_rn[0]), 64'd4);
    chk("lu ns drained", 64'(o_ov[1]), 64'd0);
    step();
    chk("lu add consumed", 64'(o_ov[0]), 64'd0);

    // Back-pressure: three offered with execute stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h91001441; in_pc = 64'h200;
    chk("bp ready A", 64'(o_ir[0]), 64'd1);
    step();
    in_pc = 64'h204;
    chk("bp ready B", 64'(o_ir[0]), 64'd1);
    step();
    in_pc = 64'h208;
    chk("bp ready C", 64'(o_ir[0]), 64'd0);
    step();
    chk("bp still full", 64'(o_ir[0]), 64'd0);
    chk("bp head stable", o_pc[0], 64'h200);
    out_ready = 1'b1;
    got_pc.delete();
    for (int c = 0; c < 12; c++) begin
      if (o_ov[0]) got_pc.push_back(o_pc[0]);
      accept = in_valid && o_ir[0];
      step();
      if (accept) in_valid = 1'b0;
    end
    chk("bp delivered count", 64'(got_pc.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_pc.size()) chk($sformatf("bp order %0d", i), got_pc[i], 64'h200 + 64'(i * 4));

    // Flush with both entries full and a new instruction offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h91001441; in_pc = 64'h300;
    step();
    in_pc = 64'h304;
    step();
    chk("fl full", 64'(o_ir[0]), 64'd0);
    in_pc = 64'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl out_valid", 64'(o_ov[0]), 64'd0);
    chk("fl in_ready", 64'(o_ir[0]), 64'd1);
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_ov[0]) cnt++;
      step();
    end
    chk("fl nothing leaks", 64'(cnt), 64'd0);

    // Reset while holding two entries
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 64'h400;
    step();
    in_pc = 64'h404;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr out_valid", 64'(o_ov[0]), 64'd0);
    chk("mr in_ready", 64'(o_ir[0]), 64'd1);
    chk("mr out_pc", o_pc[0], 64'd0);

    // Random traffic against a queue model of the stage
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      exp_ir = (mq.size() < 2);
      exp_ov = (mq.size() > 0) && !m_stall;
      chk("rnd in_ready", 64'(o_ir[0]), 64'(exp_ir));
      chk("rnd out_valid", 64'(o_ov[0]), 64'(exp_ov));
      if (exp_ov) begin
        chk("rnd pc", o_pc[0], mq[0].pc);
        chk("rnd ctrl", 64'(o_ctrl[0]), 64'(mq[0].ctrl));
        chk("rnd fields", 64'({o_rd[0], o_rn[0], o_rm[0], o_cond[0]}),
            64'({mq[0].rd, mq[0].rn, mq[0].rm, mq[0].cond}));
        chk("rnd imm", o_imm[0], mq[0].imm);
      end
      if (flush) begin
        mq.delete();
        m_stall = 0;
      end else begin
        fire = exp_ov && out_ready;
        if (fire) popped = mq.pop_front();
        if (in_valid && exp_ir) begin
          nd = ref_decode(in_instr, 1'b1);
          nd.pc = in_pc;
          mq.push_back(nd);
        end
        m_stall = fire && popped.ctrl[MEM_READ] && popped.rd != 5'd31 && mq.size() > 0 &&
                  (mq[0].rn == popped.rd || (mq[0].ctrl[REG2LOC] && mq[0].rm == popped.rd));
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
